// File: rtl/aes_block_serializer_if.sv
// ---------------------------------------------------------------------------
// aes_block_serializer_if
//   Bundles the block-in and byte-out handshakes of the AES block serializer.
//   Optional feature macro: AES_SER_LAST_EN adds the out_last signal.
//
//   Signals
//     in_block   8*NBYTES  block to serialize, byte 0 in the top 8 bits
//     in_valid   1         in_block valid
//     in_ready   1         serializer can take a block this cycle
//     out_data   8         current output byte
//     out_valid  1         out_data valid
//     out_ready  1         sink takes the byte this cycle
//     out_last   1         (AES_SER_LAST_EN only) final byte of a block
//
//   Modports
//     master  the serializer itself (drives ready/data/valid/last)
//     slave   the surrounding datapath / sink
// ---------------------------------------------------------------------------
interface aes_block_serializer_if #(
  parameter int NBYTES = 16
);
  logic [8*NBYTES-1:0] in_block;
  logic                in_valid;
  logic                in_ready;
  logic [7:0]          out_data;
  logic                out_valid;
  logic                out_ready;
`ifdef AES_SER_LAST_EN
  logic                out_last;
`endif

  modport master (
    input  in_block,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_data,
`ifdef AES_SER_LAST_EN
    output out_last,
`endif
    output out_valid
  );

  modport slave (
    output in_block,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_data,
`ifdef AES_SER_LAST_EN
    input  out_last,
`endif
    input  out_valid
  );
endinterface

// File: rtl/aes_block_serializer.sv
// ---------------------------------------------------------------------------
// aes_block_serializer
//   Parallel-to-byte-serial output stage of the byte-serial AES datapath.
//   Takes a whole block and streams it out MS byte first. An active entry
//   feeds the output shifter and a hold entry parks the next block, so
//   back-to-back blocks leave without a bubble.
//
//   Optional feature macro: AES_SER_LAST_EN adds bus.out_last, high with the
//   final byte of each block.
//
//   Ports
//     clk    rising-edge clock
//     rst    asynchronous, active-low reset
//     flush  synchronous clear of both buffer entries (wins over handshakes)
//     bus    aes_block_serializer_if.master (block in / byte out handshakes)
//
//   Parameters
//     NBYTES  bytes per block (block width 8*NBYTES)
//     CNT_W   byte-counter width, 2**CNT_W >= NBYTES
// ---------------------------------------------------------------------------
module aes_block_serializer #(
  parameter int NBYTES = 16,
  parameter int CNT_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  aes_block_serializer_if.master bus
);

  localparam int               W        = 8 * NBYTES;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

  typedef enum logic {
    ACTIVE_EMPTY,
    STREAMING
  } state_t;

  state_t           state, state_next;
  logic [W-1:0]     active, active_next;
  logic [W-1:0]     hold, hold_next;
  logic             hold_valid, hold_valid_next;
  logic [CNT_W-1:0] count, count_next;

  logic in_ready;
  logic out_valid;
  logic in_fire;
  logic out_fire;
  logic last_byte;

  // A block can only be taken while the hold slot is free, so the hold entry
  // never needs to be overwritten; flush blocks acceptance outright.
  assign in_ready  = !hold_valid && !flush;
  assign out_valid = (state == STREAMING);
  assign in_fire   = bus.in_valid && in_ready;
  assign out_fire  = out_valid && bus.out_ready;
  assign last_byte = (count == LAST_IDX);

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = active[W-1 -: 8];
`ifdef AES_SER_LAST_EN
  assign bus.out_last  = out_valid && last_byte;
`endif

  // State register plus the two buffer entries and the byte counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ACTIVE_EMPTY;
      active     <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      count      <= '0;
    end else begin
      state      <= state_next;
      active     <= active_next;
      hold       <= hold_next;
      hold_valid <= hold_valid_next;
      count      <= count_next;
    end
  end

  // Next-state logic. On the final-byte handshake the next block (from hold,
  // or straight from the input) replaces the active entry on the same edge,
  // which is what keeps consecutive blocks contiguous.
  always_comb begin
    state_next      = state;
    active_next     = active;
    hold_next       = hold;
    hold_valid_next = hold_valid;
    count_next      = count;

    if (flush) begin
      state_next      = ACTIVE_EMPTY;
      active_next     = '0;
      hold_valid_next = 1'b0;
      count_next      = '0;
    end else begin
      case (state)
        ACTIVE_EMPTY: begin
          if (in_fire) begin
            active_next = bus.in_block;
            count_next  = '0;
            state_next  = STREAMING;
          end
        end

        STREAMING: begin
          if (out_fire && last_byte) begin
            count_next = '0;
            if (hold_valid) begin
              active_next     = hold;
              hold_valid_next = 1'b0;
            end else if (in_fire) begin
              active_next = bus.in_block;
            end else begin
              // Shifted-out block leaves zeros behind, so out_data idles at 00.
              active_next = {active[W-9:0], 8'h00};
              state_next  = ACTIVE_EMPTY;
            end
          end else begin
            if (out_fire) begin
              active_next = {active[W-9:0], 8'h00};
              count_next  = count + 1'b1;
            end
            if (in_fire) begin
              hold_next       = bus.in_block;
              hold_valid_next = 1'b1;
            end
          end
        end

        default: begin
          state_next = ACTIVE_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_block_serializer.sv
// ---------------------------------------------------------------------------
// tb_aes_block_serializer
//   Self-checking bench for aes_block_serializer. The reference model is a
//   byte queue: every accepted block appends its bytes, every byte handshake
//   pops one, flush/reset empty it. Occupancy (blocks resident) is derived
//   from the queue length, which gives the expected out_valid, in_ready and,
//   with AES_SER_LAST_EN, out_last.
// ---------------------------------------------------------------------------
module tb_aes_block_serializer;

  localparam int NBYTES = 16;
  localparam logic [127:0] BLK_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] BLK_B = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] BLK_C = 128'h00112233445566778899aabbccddeeff;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  aes_block_serializer_if #(.NBYTES(NBYTES)) bus ();

  aes_block_serializer #(.NBYTES(NBYTES), .CNT_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int assert_count = 0;
  int fail_count   = 0;
  byte unsigned exp_q[$];

  // One comparison: counts it, and reports tag/observed/expected on failure.
  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check outputs
  // against the model, then advance the model on the rising edge.
  task automatic apply_stimulus(input logic v, input logic [127:0] blk,
                                input logic rdy, input logic fl);
    int   resident;
    logic exp_valid;
    logic exp_ready;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_block  = blk;
    bus.out_ready = rdy;
    flush         = fl;
    #1;
    resident  = (exp_q.size() + NBYTES - 1) / NBYTES;
    exp_valid = (resident > 0);
    exp_ready = (resident < 2) && !fl;
    check_output("out_valid", 128'(bus.out_valid), 128'(exp_valid));
    check_output("in_ready", 128'(bus.in_ready), 128'(exp_ready));
    if (exp_valid)
      check_output("out_data", 128'(bus.out_data), 128'(exp_q[0]));
`ifdef AES_SER_LAST_EN
    check_output("out_last", 128'(bus.out_last),
                 128'(exp_valid && (exp_q.size() % NBYTES == 1)));
`endif
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (exp_valid && rdy) void'(exp_q.pop_front());
      if (v && exp_ready)
        for (int i = 0; i < NBYTES; i++) exp_q.push_back(blk[8*(NBYTES-1-i) +: 8]);
    end
  endtask

  // Asserts reset away from any clock edge and checks the outputs clear at once.
  task automatic async_reset_mid_cycle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    flush        = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_output("rst_out_valid", 128'(bus.out_valid), 128'(1'b0));
    check_output("rst_out_data", 128'(bus.out_data), 128'(8'h00));
    check_output("rst_in_ready", 128'(bus.in_ready), 128'(1'b1));
`ifdef AES_SER_LAST_EN
    check_output("rst_out_last", 128'(bus.out_last), 128'(1'b0));
`endif
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() > 0; i++)
      apply_stimulus(1'b0, BLK_C, 1'b1, 1'b0);
    check_output("drain_empty", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    logic [127:0] rnd_blk;

    // Power-on reset
    rst           = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_block  = '0;
    bus.out_ready = 1'b0;
    #1;
    check_output("reset_out_valid", 128'(bus.out_valid), 128'(1'b0));
    check_output("reset_out_data", 128'(bus.out_data), 128'(8'h00));
    check_output("reset_in_ready", 128'(bus.in_ready), 128'(1'b1));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Single block at full rate
    apply_stimulus(1'b1, BLK_A, 1'b1, 1'b0);
    for (int i = 0; i < 18; i++) apply_stimulus(1'b0, BLK_B, 1'b1, 1'b0);

    // Backpressure: out_ready alternates
    apply_stimulus(1'b1, BLK_A, 1'b0, 1'b0);
    for (int i = 0; i < 34; i++) apply_stimulus(1'b0, BLK_B, 1'(i % 2), 1'b0);

    // Back-to-back A, B, then C held valid until it is taken
    apply_stimulus(1'b1, BLK_A, 1'b1, 1'b0);
    apply_stimulus(1'b1, BLK_B, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) apply_stimulus(1'b1, BLK_C, 1'b1, 1'b0);
    drain();

    // Stall on a last byte with B waiting in hold
    apply_stimulus(1'b1, BLK_A, 1'b1, 1'b0);
    apply_stimulus(1'b1, BLK_B, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) apply_stimulus(1'b0, BLK_C, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, BLK_C, 1'b0, 1'b0);
    drain();

    // Flush at byte 5 of A with B in hold, new block offered during flush
    apply_stimulus(1'b1, BLK_A, 1'b1, 1'b0);
    apply_stimulus(1'b1, BLK_B, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, BLK_C, 1'b1, 1'b0);
    apply_stimulus(1'b1, BLK_C, 1'b1, 1'b1);
    apply_stimulus(1'b0, BLK_C, 1'b1, 1'b0);
    apply_stimulus(1'b1, BLK_C, 1'b1, 1'b0);
    drain();

    // Asynchronous reset at byte 9
    apply_stimulus(1'b1, BLK_A, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) apply_stimulus(1'b0, BLK_B, 1'b1, 1'b0);
    async_reset_mid_cycle();
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, BLK_B, 1'b1, 1'b0);
    apply_stimulus(1'b1, BLK_B, 1'b1, 1'b0);
    drain();

    // Randomised traffic, including rare flushes
    for (int i = 0; i < 600; i++) begin
      rnd_blk = {$urandom, $urandom, $urandom, $urandom};
      apply_stimulus(1'($urandom_range(0, 3) != 0), rnd_blk,
                     1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 59) == 0));
    end
    drain();
    apply_stimulus(1'b0, BLK_A, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
